// File: rtl/dmem_responder_if.sv
// Bus between the M-stage datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        ErrM;
  logic [31:0] ErrAddr;
  logic [31:0] StallCount;

  modport master (
    output MemWriteM, MemReadM, ALUOutM, WriteDataM,
    input  ReadDataM, StallM, ErrM, ErrAddr, StallCount
  );

  modport slave (
    input  MemWriteM, MemReadM, ALUOutM, WriteDataM,
    output ReadDataM, StallM, ErrM, ErrAddr, StallCount
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: a word-addressed RAM with a programmable number of wait
// states. It raises StallM while an access is outstanding, records the most
// recent misaligned address, and counts stall cycles.
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LAST = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAITING, READY} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] err_addr_reg;
  logic [31:0] stall_count_reg;
  logic [31:0] mem [DEPTH];

  logic          req, is_store, aligned;
  logic          stall, complete, wr_en;
  logic [AW-1:0] idx;

  assign req      = bus.MemWriteM | bus.MemReadM;
  assign is_store = bus.MemWriteM;
  assign aligned  = (bus.ALUOutM[1:0] == 2'b00);
  assign idx      = bus.ALUOutM[AW+1:2];

  // Next state, wait counter and Mealy outputs; everything is forced quiet while
  // reset is held so an in-flight access can never complete or write.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            complete = 1'b1;
          end else begin
            stall = 1'b1;
            if (WAIT == 1) begin
              state_next = READY;
            end else begin
              state_next = WAITING;
              cnt_next   = 3'd1;
            end
          end
        end
      end
      WAITING: begin
        if (!req) begin
          state_next = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_reg == WAIT_LAST) state_next = READY;
          else cnt_next = cnt_reg + 3'd1;
        end
      end
      READY: begin
        state_next = IDLE;
        complete   = req;
      end
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      stall    = 1'b0;
      complete = 1'b0;
    end
  end

  assign wr_en = complete & is_store & aligned;

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sticky misaligned address and saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_addr_reg    <= 32'd0;
      stall_count_reg <= 32'd0;
    end else begin
      if (complete && !aligned) err_addr_reg <= bus.ALUOutM;
      if (stall && stall_count_reg != 32'hFFFF_FFFF) stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  // RAM write port; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= bus.WriteDataM;
  end

  assign bus.StallM     = stall;
  assign bus.ErrM       = complete & ~aligned;
  assign bus.ReadDataM  = (complete && !is_store && aligned) ? mem[idx] : 32'd0;
  assign bus.ErrAddr    = err_addr_reg;
  assign bus.StallCount = stall_count_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT = 2, 0 and 3 instances.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if i2();
  dmem_responder_if i0();
  dmem_responder_if i3();

  dmem_responder #(.DEPTH(64), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(i2));
  dmem_responder #(.DEPTH(64), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(i0));
  dmem_responder #(.DEPTH(64), .WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(i3));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full WAIT=2 access: two stall cycles, then completion; request dropped afterwards.
  task automatic run_d2(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    step();
    i2.MemWriteM = we; i2.MemReadM = ~we; i2.ALUOutM = addr; i2.WriteDataM = wdata;
    #1;
    check_value({tag, "_stall0"}, 32'(i2.StallM), 32'd1);
    step(); #1;
    check_value({tag, "_stall1"}, 32'(i2.StallM), 32'd1);
    step(); #1;
    check_value({tag, "_stall2"}, 32'(i2.StallM), 32'd0);
    check_value({tag, "_rd"}, i2.ReadDataM, exp_rd);
    check_value({tag, "_err"}, 32'(i2.ErrM), 32'(exp_err));
    $display("txn w2 %s we=%0d addr=%h wdata=%h rd=%h err=%0d", tag, we, addr, wdata, i2.ReadDataM, i2.ErrM);
    step();
    i2.MemWriteM = 1'b0; i2.MemReadM = 1'b0;
    #1;
  endtask

  // One full WAIT=3 access.
  task automatic run_d3(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    step();
    i3.MemWriteM = we; i3.MemReadM = ~we; i3.ALUOutM = addr; i3.WriteDataM = wdata;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("%s_stall%0d", tag, k), 32'(i3.StallM), 32'd1);
      step(); #1;
    end
    check_value({tag, "_done"}, 32'(i3.StallM), 32'd0);
    check_value({tag, "_rd"}, i3.ReadDataM, exp_rd);
    $display("txn w3 %s we=%0d addr=%h wdata=%h rd=%h", tag, we, addr, wdata, i3.ReadDataM);
    step();
    i3.MemWriteM = 1'b0; i3.MemReadM = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i2.MemWriteM = 0; i2.MemReadM = 0; i2.ALUOutM = 0; i2.WriteDataM = 0;
    i0.MemWriteM = 0; i0.MemReadM = 0; i0.ALUOutM = 0; i0.WriteDataM = 0;
    i3.MemWriteM = 0; i3.MemReadM = 0; i3.ALUOutM = 0; i3.WriteDataM = 0;

    // Reset state
    step(); #1;
    check_value("rst_stall", 32'(i2.StallM), 32'd0);
    check_value("rst_err", 32'(i2.ErrM), 32'd0);
    check_value("rst_rd", i2.ReadDataM, 32'd0);
    check_value("rst_erraddr", i2.ErrAddr, 32'd0);
    check_value("rst_stallcnt", i2.StallCount, 32'd0);
    reset = 1'b1;

    // WAIT=2 aligned store then load
    run_d2("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    run_d2("ld10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    check_value("stallcnt_w2", i2.StallCount, 32'd4);

    // WAIT=0 store then load next cycle
    step();
    i0.MemWriteM = 1; i0.ALUOutM = 32'h8; i0.WriteDataM = 32'h1234;
    #1;
    check_value("w0_st_stall", 32'(i0.StallM), 32'd0);
    $display("txn w0 store addr=00000008 wdata=00001234");
    step();
    i0.MemWriteM = 0; i0.MemReadM = 1;
    #1;
    check_value("w0_ld_stall", 32'(i0.StallM), 32'd0);
    check_value("w0_ld_rd", i0.ReadDataM, 32'h1234);
    $display("txn w0 load addr=00000008 rd=%h", i0.ReadDataM);
    step();
    i0.MemReadM = 0;
    #1;
    check_value("w0_stallcnt", i0.StallCount, 32'd0);

    // Misaligned accesses
    run_d2("mis_ld13", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
    check_value("mis_err_pulse", 32'(i2.ErrM), 32'd0);
    check_value("mis_erraddr13", i2.ErrAddr, 32'h13);
    run_d2("mis_st12", 1'b1, 32'h12, 32'h0, 32'd0, 1'b1);
    check_value("mis_erraddr12", i2.ErrAddr, 32'h12);
    run_d2("ld10_keep", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Wrap-around
    run_d2("st100", 1'b1, 32'h100, 32'hA5A5A5A5, 32'd0, 1'b0);
    run_d2("ld0", 1'b0, 32'h0, 32'd0, 32'hA5A5A5A5, 1'b0);

    // Abort with WAIT=3
    run_d3("st4_old", 1'b1, 32'h4, 32'h11, 32'd0);
    step();
    i3.MemWriteM = 1; i3.ALUOutM = 32'h4; i3.WriteDataM = 32'h55;
    #1;
    check_value("abort_stall0", 32'(i3.StallM), 32'd1);
    step();
    i3.MemWriteM = 0;
    #1;
    check_value("abort_stall_drop", 32'(i3.StallM), 32'd0);
    check_value("abort_err", 32'(i3.ErrM), 32'd0);
    $display("txn w3 abort store addr=00000004 wdata=00000055");
    run_d3("ld4_after_abort", 1'b0, 32'h4, 32'd0, 32'h11);

    // Reset while WAITING
    step();
    i3.MemWriteM = 1; i3.ALUOutM = 32'h4; i3.WriteDataM = 32'h77;
    step(); #1;
    reset = 1'b0;
    #1;
    check_value("rstmid_stall", 32'(i3.StallM), 32'd0);
    check_value("rstmid_rd", i3.ReadDataM, 32'd0);
    check_value("rstmid_err", 32'(i3.ErrM), 32'd0);
    check_value("rstmid_stallcnt", i3.StallCount, 32'd0);
    check_value("rstmid_erraddr_w2", i2.ErrAddr, 32'd0);
    $display("txn w3 reset during store addr=00000004 wdata=00000077");
    step();
    i3.MemWriteM = 0;
    step();
    reset = 1'b1;
    run_d3("ld4_after_rst", 1'b0, 32'h4, 32'd0, 32'h11);
    check_value("stallcnt_after_rst", i3.StallCount, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
